// File: rtl/sub_divider_pkg.sv
// Shared definitions for the sequential subtract-and-count divider.
package sub_divider_pkg;

  // Default operand/quotient/remainder width.
  localparam int WIDTH_DEFAULT = 4;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_divider_sub.sv
// The team's modular subtractor: o_diff = i_a_in - i_b_in mod 2^WIDTH.
module sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a_in,
  input  logic [WIDTH-1:0] i_b_in,
  output logic [WIDTH-1:0] o_diff
);

  assign o_diff = i_a_in - i_b_in;

endmodule

// File: rtl/sub_divider.sv
// Sequential unsigned divider: repeatedly subtracts the divisor from a
// running remainder, counting subtractions as the quotient.
module sub_divider
  import sub_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Difference is only consumed when r_rem >= r_div, so it never wraps.
  sub #(.WIDTH(WIDTH)) u_sub (
    .i_a_in (r_rem),
    .i_b_in (r_div),
    .o_diff (w_diff)
  );

  assign w_ge = (r_rem >= r_div);

  // Controller FSM with datapath registers and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_rem   <= dividend;
            r_div   <= divisor;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ST_ITER;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_ITER: begin
          if (r_div == '0) begin
            quotient    <= '1;
            remainder   <= r_rem;
            div_by_zero <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            r_state     <= ST_DONE;
          end else if (w_ge) begin
            r_rem <= w_diff;
            r_cnt <= r_cnt + WIDTH'(1);
          end else begin
            quotient    <= r_cnt;
            remainder   <= r_rem;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
